mem_access_initiator: RTL and testbench

- CPU-side initiator for the word-addressed, single-port instruction/data memory. The memory responds with a registered read.
- Accepts byte-addressed load/store requests of byte, half or word size.
- Drives the memory's word address, write data, write enable, read enable and enable (E) lines. Performs read-modify-write for sub-word stores.
- Returns extracted, sign/zero-extended load data or a store acknowledge through a valid pulse. Sits between the pipeline MEM stage and the memory.

---
 rtl/mem_access_initiator.sv | 176 +++++++++++++++++
 tb/tb_mem_access_initiator.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_initiator.sv
// CPU-side load/store initiator for a word-addressed, registered-read memory.
// Handles big-endian byte/half extraction and read-modify-write for sub-word stores.
module mem_access_initiator #(
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic        resp_err,
  output logic [31:0] resp_rdata,
  output logic [29:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_wren,
  output logic        mem_rren,
  output logic        mem_E,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [2:0] {IDLE, RD, RD_WAIT, WR, RESP} state_t;

  localparam logic [1:0] LAST_WAIT = 2'(READ_LATENCY - 1);

  state_t      state, next_state;
  logic [1:0]  wait_cnt;
  logic        we_q, signed_q;
  logic [1:0]  size_q, off_q;
  logic [15:0] wdata_q;
  logic        accept, req_err, wait_done;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [31:0] load_data, merged;

  logic        req_ready_d, mem_rren_d, mem_wren_d, resp_valid_d, resp_err_d;
  logic [29:0] mem_addr_d;
  logic [31:0] mem_wdata_d, resp_rdata_d;

  always_comb begin
    accept    = (state == IDLE) && req_valid;
    wait_done = (wait_cnt == LAST_WAIT);
    unique case (req_size)
      2'b00:   req_err = 1'b0;
      2'b01:   req_err = req_addr[0];
      2'b10:   req_err = |req_addr[1:0];
      default: req_err = 1'b1;
    endcase
  end

  // Big-endian lanes: offset 0 is the most significant byte/half.
  always_comb begin
    unique case (off_q)
      2'd0:    lane_b = mem_rdata[31:24];
      2'd1:    lane_b = mem_rdata[23:16];
      2'd2:    lane_b = mem_rdata[15:8];
      default: lane_b = mem_rdata[7:0];
    endcase
    lane_h = off_q[1] ? mem_rdata[15:0] : mem_rdata[31:16];

    unique case (size_q)
      2'b00:   load_data = {{24{signed_q & lane_b[7]}}, lane_b};
      2'b01:   load_data = {{16{signed_q & lane_h[15]}}, lane_h};
      default: load_data = mem_rdata;
    endcase

    merged = mem_rdata;
    if (size_q == 2'b00) begin
      unique case (off_q)
        2'd0:    merged[31:24] = wdata_q[7:0];
        2'd1:    merged[23:16] = wdata_q[7:0];
        2'd2:    merged[15:8]  = wdata_q[7:0];
        default: merged[7:0]   = wdata_q[7:0];
      endcase
    end else if (off_q[1]) begin
      merged[15:0] = wdata_q;
    end else begin
      merged[31:16] = wdata_q;
    end
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: begin
        if (req_valid) begin
          if (req_err)
            next_state = RESP;
          else if (req_we && req_size == 2'b10)
            next_state = WR;
          else
            next_state = RD;
        end
      end
      RD:      next_state = RD_WAIT;
      RD_WAIT: if (wait_done) next_state = we_q ? WR : RESP;
      WR:      next_state = RESP;
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Outputs are registered, so they are derived from the state being entered.
  always_comb begin
    req_ready_d  = (next_state == IDLE);
    mem_rren_d   = (next_state == RD);
    mem_wren_d   = (next_state == WR);
    resp_valid_d = (next_state == RESP);
    resp_err_d   = accept && req_err;
    resp_rdata_d = '0;
    mem_addr_d   = mem_addr;
    mem_wdata_d  = mem_wdata;
    if (accept && !req_err) begin
      mem_addr_d = req_addr[31:2];
      if (req_we && req_size == 2'b10)
        mem_wdata_d = req_wdata;
    end
    if (state == RD_WAIT && wait_done) begin
      if (we_q)
        mem_wdata_d = merged;
      else
        resp_rdata_d = load_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      req_ready  <= 1'b1;
      mem_rren   <= 1'b0;
      mem_wren   <= 1'b0;
      mem_E      <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
    end else begin
      state      <= next_state;
      req_ready  <= req_ready_d;
      mem_rren   <= mem_rren_d;
      mem_wren   <= mem_wren_d;
      mem_E      <= mem_rren_d | mem_wren_d;
      mem_addr   <= mem_addr_d;
      mem_wdata  <= mem_wdata_d;
      resp_valid <= resp_valid_d;
      resp_err   <= resp_err_d;
      resp_rdata <= resp_rdata_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      we_q     <= 1'b0;
      signed_q <= 1'b0;
      size_q   <= '0;
      off_q    <= '0;
      wdata_q  <= '0;
      wait_cnt <= '0;
    end else begin
      if (accept) begin
        we_q     <= req_we;
        signed_q <= req_signed;
        size_q   <= req_size;
        off_q    <= req_addr[1:0];
        wdata_q  <= req_wdata[15:0];
      end
      wait_cnt <= (state == RD_WAIT) ? wait_cnt + 2'd1 : '0;
    end
  end

endmodule

// File: tb/tb_mem_access_initiator.sv
// Directed bench for mem_access_initiator: one instance at READ_LATENCY=1 and one at
// READ_LATENCY=3, each with a registered-read memory whose data is only valid on the sampling edge.
module tb_mem_access_initiator;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic preload = 1'b1;

  logic        req_valid = 1'b0, req_we = 1'b0, req_signed = 1'b0;
  logic [1:0]  req_size = '0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        req_ready, resp_valid, resp_err, mem_wren, mem_rren, mem_E;
  logic [31:0] resp_rdata, mem_wdata, mem_rdata;
  logic [29:0] mem_addr;

  logic        r3_valid = 1'b0, r3_signed = 1'b0;
  logic        r3_we = 1'b0;
  logic [1:0]  r3_size = '0;
  logic [31:0] r3_addr = '0, r3_wdata = '0;
  logic        req_ready3, resp_valid3, resp_err3, mem_wren3, mem_rren3, mem_E3;
  logic [31:0] resp_rdata3, mem_wdata3, mem_rdata3;
  logic [29:0] mem_addr3;

  int n_checks = 0, n_errors = 0;
  int rren_cnt = 0, wren_cnt = 0, resp_cnt = 0, rren_cnt3 = 0, resp_cnt3 = 0, viol = 0;
  logic [29:0] strobe_addr = '0;
  logic [31:0] wr_word = '0;

  logic [31:0] mem1 [256];
  logic [31:0] mem3 [256];
  logic [31:0] rd1, p0, p1, p2;

  mem_access_initiator #(.READ_LATENCY(1)) u_dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wren(mem_wren), .mem_rren(mem_rren), .mem_E(mem_E),
    .mem_rdata(mem_rdata)
  );

  mem_access_initiator #(.READ_LATENCY(3)) u_dut3 (
    .clk(clk), .rst(rst), .req_valid(r3_valid), .req_ready(req_ready3), .req_we(r3_we),
    .req_size(r3_size), .req_signed(r3_signed), .req_addr(r3_addr), .req_wdata(r3_wdata),
    .resp_valid(resp_valid3), .resp_err(resp_err3), .resp_rdata(resp_rdata3), .mem_addr(mem_addr3),
    .mem_wdata(mem_wdata3), .mem_wren(mem_wren3), .mem_rren(mem_rren3), .mem_E(mem_E3),
    .mem_rdata(mem_rdata3)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (preload) begin
      mem1[8'h40] <= 32'h0;
      mem1[8'h80] <= 32'h80F17F01;
      mem1[8'hC0] <= 32'h11223344;
    end else if (mem_E && mem_wren) begin
      mem1[mem_addr[7:0]] <= mem_wdata;
    end
    rd1 <= (mem_E && mem_rren) ? mem1[mem_addr[7:0]] : 32'hDEADBEEF;
  end
  assign mem_rdata = rd1;

  always @(posedge clk) begin
    if (preload)
      mem3[8'h80] <= 32'h80F17F01;
    p0 <= (mem_E3 && mem_rren3) ? mem3[mem_addr3[7:0]] : 32'hDEADBEEF;
    p1 <= p0;
    p2 <= p1;
  end
  assign mem_rdata3 = p2;

  always @(negedge clk) begin
    if (mem_rren) rren_cnt++;
    if (mem_wren) begin
      wren_cnt++;
      wr_word = mem_wdata;
    end
    if (mem_rren || mem_wren) strobe_addr = mem_addr;
    if (resp_valid) resp_cnt++;
    if ((mem_rren && mem_wren) || (mem_E != (mem_rren || mem_wren)) ||
        ((mem_rren || mem_wren) && mem_addr[29:8] != '0))
      viol++;
    if (mem_rren3) rren_cnt3++;
    if (resp_valid3) resp_cnt3++;
    if (mem_wren3) begin
      viol++;
      wr_word = mem_wdata3;
    end
    if ((mem_E3 != mem_rren3) || (mem_rren3 && mem_addr3[29:8] != '0) || resp_err3)
      viol++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic xact(input string tag, input logic we, input logic [1:0] size, input logic sgn,
                      input logic [31:0] addr, input logic [31:0] wd, input int exp_lat,
                      input logic [31:0] exp_rdata, input logic exp_err, input int exp_nr,
                      input int exp_nw, input logic [31:0] exp_wword, input logic [29:0] exp_maddr);
    int lat;
    @(negedge clk);
    check({tag, ".ready"}, 32'(req_ready), 32'd1);
    rren_cnt = 0; wren_cnt = 0; resp_cnt = 0; wr_word = '0;
    req_we = we; req_size = size; req_signed = sgn; req_addr = addr; req_wdata = wd;
    req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 0;
    while (!resp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check({tag, ".lat"}, 32'(lat), 32'(exp_lat));
    check({tag, ".rdata"}, resp_rdata, exp_rdata);
    check({tag, ".err"}, 32'(resp_err), 32'(exp_err));
    check({tag, ".busy"}, 32'(req_ready), 32'd0);
    @(negedge clk);
    check({tag, ".pulse"}, 32'(resp_valid), 32'd0);
    check({tag, ".nrd"}, 32'(rren_cnt), 32'(exp_nr));
    check({tag, ".nwr"}, 32'(wren_cnt), 32'(exp_nw));
    check({tag, ".nresp"}, 32'(resp_cnt), 32'd1);
    if (exp_nw != 0) check({tag, ".wword"}, wr_word, exp_wword);
    if (exp_nr + exp_nw != 0) check({tag, ".maddr"}, 32'(strobe_addr), 32'(exp_maddr));
  endtask

  task automatic do3(input string tag, input logic [1:0] size, input logic sgn,
                     input logic [31:0] addr, input logic [31:0] exp_rdata);
    int lat;
    @(negedge clk);
    rren_cnt3 = 0;
    r3_size = size; r3_signed = sgn; r3_addr = addr; r3_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    r3_valid = 1'b0;
    lat = 0;
    while (!resp_valid3 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check({tag, ".lat"}, 32'(lat), 32'd4);
    check({tag, ".rdata"}, resp_rdata3, exp_rdata);
    @(negedge clk);
    check({tag, ".nrd"}, 32'(rren_cnt3), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    preload = 1'b0;
    check("reset.ready", 32'(req_ready), 32'd1);
    check("reset.ready3", 32'(req_ready3), 32'd1);
    check("reset.strobes", {29'd0, mem_E, mem_rren, mem_wren}, 32'd0);
    check("reset.resp", {30'd0, resp_valid, resp_err}, 32'd0);
    check("reset.rdata", resp_rdata, 32'd0);
    check("reset.maddr", 32'(mem_addr), 32'd0);
    check("reset.wdata", mem_wdata, 32'd0);

    //    tag        we    size   sgn   addr          wdata         lat rdata         err  nr nw wword         maddr
    xact("st_w",     1'b1, 2'b10, 1'b0, 32'h00000100, 32'h00000064, 1, 32'h00000000, 1'b0, 0, 1, 32'h00000064, 30'h40);
    xact("ld_w",     1'b0, 2'b10, 1'b0, 32'h00000100, 32'h0,        2, 32'h00000064, 1'b0, 1, 0, 32'h0,        30'h40);
    xact("ld_sb0",   1'b0, 2'b00, 1'b1, 32'h00000200, 32'h0,        2, 32'hFFFFFF80, 1'b0, 1, 0, 32'h0,        30'h80);
    xact("ld_ub1",   1'b0, 2'b00, 1'b0, 32'h00000201, 32'h0,        2, 32'h000000F1, 1'b0, 1, 0, 32'h0,        30'h80);
    xact("ld_sh2",   1'b0, 2'b01, 1'b1, 32'h00000202, 32'h0,        2, 32'h00007F01, 1'b0, 1, 0, 32'h0,        30'h80);
    xact("ld_sh0",   1'b0, 2'b01, 1'b1, 32'h00000200, 32'h0,        2, 32'hFFFF80F1, 1'b0, 1, 0, 32'h0,        30'h80);
    xact("ld_uh0",   1'b0, 2'b01, 1'b0, 32'h00000200, 32'h0,        2, 32'h000080F1, 1'b0, 1, 0, 32'h0,        30'h80);
    xact("ld_sb1",   1'b0, 2'b00, 1'b1, 32'h00000201, 32'h0,        2, 32'hFFFFFFF1, 1'b0, 1, 0, 32'h0,        30'h80);
    xact("ld_ub3",   1'b0, 2'b00, 1'b0, 32'h00000203, 32'h0,        2, 32'h00000001, 1'b0, 1, 0, 32'h0,        30'h80);
    xact("ld_ws",    1'b0, 2'b10, 1'b1, 32'h00000200, 32'h0,        2, 32'h80F17F01, 1'b0, 1, 0, 32'h0,        30'h80);
    xact("st_b1",    1'b1, 2'b00, 1'b0, 32'h00000301, 32'h123456AA, 3, 32'h00000000, 1'b0, 1, 1, 32'h11AA3344, 30'hC0);
    xact("st_h2",    1'b1, 2'b01, 1'b0, 32'h00000302, 32'hCAFEBEEF, 3, 32'h00000000, 1'b0, 1, 1, 32'h11AABEEF, 30'hC0);
    xact("st_b3",    1'b1, 2'b00, 1'b0, 32'h00000303, 32'h00000055, 3, 32'h00000000, 1'b0, 1, 1, 32'h11AABE55, 30'hC0);
    xact("st_h0",    1'b1, 2'b01, 1'b0, 32'h00000300, 32'h00001234, 3, 32'h00000000, 1'b0, 1, 1, 32'h1234BE55, 30'hC0);
    xact("ld_w300",  1'b0, 2'b10, 1'b0, 32'h00000300, 32'h0,        2, 32'h1234BE55, 1'b0, 1, 0, 32'h0,        30'hC0);
    xact("err_lh",   1'b0, 2'b01, 1'b0, 32'h00000101, 32'h0,        0, 32'h00000000, 1'b1, 0, 0, 32'h0,        30'h0);
    xact("err_sw",   1'b1, 2'b10, 1'b0, 32'h00000102, 32'hFFFFFFFF, 0, 32'h00000000, 1'b1, 0, 0, 32'h0,        30'h0);
    xact("err_sz",   1'b0, 2'b11, 1'b0, 32'h00000100, 32'h0,        0, 32'h00000000, 1'b1, 0, 0, 32'h0,        30'h0);
    xact("err_sh",   1'b1, 2'b01, 1'b0, 32'h00000103, 32'h0000FFFF, 0, 32'h00000000, 1'b1, 0, 0, 32'h0,        30'h0);
    xact("ld_after", 1'b0, 2'b10, 1'b0, 32'h00000100, 32'h0,        2, 32'h00000064, 1'b0, 1, 0, 32'h0,        30'h40);

    // Abort a sub-word store while it waits on read data.
    @(negedge clk);
    rren_cnt = 0; wren_cnt = 0; resp_cnt = 0;
    req_we = 1'b1; req_size = 2'b00; req_signed = 1'b0; req_addr = 32'h00000302; req_wdata = 32'h77;
    req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check("rst.rd_phase", 32'(mem_rren), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst.strobes", {29'd0, mem_E, mem_rren, mem_wren}, 32'd0);
    check("rst.resp", 32'(resp_valid), 32'd0);
    check("rst.maddr", 32'(mem_addr), 32'd0);
    check("rst.wdata", mem_wdata, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("rst.nresp", 32'(resp_cnt), 32'd0);
    check("rst.nwr", 32'(wren_cnt), 32'd0);
    check("rst.nrd", 32'(rren_cnt), 32'd1);
    check("rst.ready", 32'(req_ready), 32'd1);
    xact("rst.ld",   1'b0, 2'b10, 1'b0, 32'h00000300, 32'h0,        2, 32'h1234BE55, 1'b0, 1, 0, 32'h0,        30'hC0);

    do3("rl3_w",  2'b10, 1'b0, 32'h00000200, 32'h80F17F01);
    do3("rl3_sb", 2'b00, 1'b1, 32'h00000201, 32'hFFFFFFF1);
    do3("rl3_uh", 2'b01, 1'b0, 32'h00000202, 32'h00007F01);

    // 13 edges of continuous req_valid: accepts land 6 edges apart (1, 7, 13).
    @(negedge clk);
    rren_cnt3 = 0; resp_cnt3 = 0;
    r3_size = 2'b10; r3_signed = 1'b0; r3_addr = 32'h00000200; r3_valid = 1'b1;
    repeat (13) @(posedge clk);
    @(negedge clk);
    r3_valid = 1'b0;
    repeat (10) @(negedge clk);
    check("hold.naccept", 32'(rren_cnt3), 32'd3);
    check("hold.nresp", 32'(resp_cnt3), 32'd3);
    check("hold.ready", 32'(req_ready3), 32'd1);

    check("strobe_rules", 32'(viol), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
